// File: rtl/mat_row_pkg.sv
// rtl/mat_row_pkg.sv - shared types and constants for the row-addressed complex matrix store
package mat_row_pkg;

    localparam int MAT_SIZE  = 4;
    localparam int MAT_WIDTH = 64;
    localparam int AW        = $clog2(MAT_SIZE);

    typedef struct packed {
        logic [MAT_WIDTH-1:0] imag;
        logic [MAT_WIDTH-1:0] real_part;
    } cplx_t;

    typedef cplx_t [MAT_SIZE-1:0] row_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        SERVE   = 2'd2,
        DUMPING = 2'd3
    } srv_state_e;

endpackage

// File: rtl/mat_row_rf.sv
// rtl/mat_row_rf.sv - SIZE-row flop array: one registered read, one row write, combinational peek
// Column write port present when MAT_ROW_SERVER_COLWR_EN is defined.
module mat_row_rf
    import mat_row_pkg::*;
#(
    parameter int SIZE  = MAT_SIZE,
    parameter int WIDTH = MAT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rd_en_i,
    input  logic [$clog2(SIZE)-1:0]       rd_addr_i,
    output logic [SIZE*2*WIDTH-1:0]       rd_row_o,
    input  logic [$clog2(SIZE)-1:0]       peek_addr_i,
    output logic [SIZE*2*WIDTH-1:0]       peek_row_o,
    input  logic                          wr_en_i,
    input  logic [$clog2(SIZE)-1:0]       wr_addr_i,
    input  logic [SIZE*2*WIDTH-1:0]       wr_row_i
`ifdef MAT_ROW_SERVER_COLWR_EN
    ,
    input  logic                          col_en_i,
    input  logic [$clog2(SIZE)-1:0]       col_addr_i,
    input  logic [SIZE*2*WIDTH-1:0]       col_i
`endif
);

    localparam int EW = 2 * WIDTH;
    localparam int RW = SIZE * EW;

    logic [RW-1:0] mem [SIZE];

    // Contents are deliberately not reset; a fresh load overwrites every row.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_row_i;
        end
`ifdef MAT_ROW_SERVER_COLWR_EN
        if (col_en_i) begin
            for (int k = 0; k < SIZE; k++) begin
                mem[k][col_addr_i*EW +: EW] <= col_i[k*EW +: EW];
            end
        end
`endif
    end

    // Nonblocking update of mem gives read-before-write on same-address collisions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_row_o <= '0;
        end else if (rd_en_i) begin
            rd_row_o <= mem[rd_addr_i];
        end
    end

    assign peek_row_o = mem[peek_addr_i];

endmodule

// File: rtl/mat_row_server.sv
// rtl/mat_row_server.sv - complex matrix row server: host load/dump, engine row read/write
// Optional column write port enabled by defining MAT_ROW_SERVER_COLWR_EN.
module mat_row_server
    import mat_row_pkg::*;
#(
    parameter int SIZE  = MAT_SIZE,
    parameter int WIDTH = MAT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [SIZE*2*WIDTH-1:0]       ld_row_i,
    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    output logic                          loaded_o,
    input  logic [$clog2(SIZE)-1:0]       rd_addr_i,
    input  logic                          rd_valid_i,
    output logic [SIZE*2*WIDTH-1:0]       rd_row_o,
    output logic [$clog2(SIZE)-1:0]       rd_addr_o,
    output logic                          rd_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]       wr_row_i,
    input  logic [$clog2(SIZE)-1:0]       wr_addr_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic                          dump_start_i,
    output logic [SIZE*2*WIDTH-1:0]       dump_row_o,
    output logic [$clog2(SIZE)-1:0]       dump_addr_o,
    output logic                          dump_valid_o,
    input  logic                          dump_ready_i,
    output logic                          busy_o
`ifdef MAT_ROW_SERVER_COLWR_EN
    ,
    input  logic [SIZE*2*WIDTH-1:0]       col_i,
    input  logic [$clog2(SIZE)-1:0]       col_addr_i,
    input  logic                          col_valid_i,
    output logic                          col_ready_o
`endif
);

    localparam int AWL = $clog2(SIZE);
    localparam logic [AWL-1:0] LAST = AWL'(SIZE - 1);

    srv_state_e           state_q, state_d;
    logic [AWL-1:0]       ld_cnt_q;
    logic                 serve, dumping;
    logic                 ld_fire, ld_last;
    logic                 rd_en, eng_wr;
    logic                 dump_start_fire, dump_fire, dump_last;
    logic                 rf_wr_en;
    logic [AWL-1:0]       rf_wr_addr;
    logic [SIZE*2*WIDTH-1:0] rf_wr_row;
    logic [AWL-1:0]       peek_addr;
    logic [SIZE*2*WIDTH-1:0] peek_row;

    assign serve      = (state_q == SERVE);
    assign dumping    = (state_q == DUMPING);
    assign ld_ready_o = (state_q == EMPTY) || (state_q == LOADING);
    assign loaded_o   = serve;
    assign wr_ready_o = serve;
    assign busy_o     = (state_q == LOADING) || dumping;

    // flush_i masks every event so nothing lands in the cycle it is asserted.
    assign ld_fire         = ld_valid_i && ld_ready_o && !flush_i;
    assign ld_last         = (ld_cnt_q == LAST);
    assign rd_en           = rd_valid_i && serve && !flush_i;
    assign eng_wr          = wr_valid_i && serve && !flush_i;
    assign dump_start_fire = dump_start_i && serve && !flush_i;
    assign dump_fire       = dumping && dump_valid_o && dump_ready_i && !flush_i;
    assign dump_last       = (dump_addr_o == LAST);

    assign rf_wr_en   = ld_fire || eng_wr;
    assign rf_wr_addr = ld_fire ? ld_cnt_q : wr_addr_i;
    assign rf_wr_row  = ld_fire ? ld_row_i : wr_row_i;
    // Prefetch the row that follows the one currently presented on the dump port.
    assign peek_addr  = dumping ? (dump_addr_o + AWL'(1)) : '0;

`ifdef MAT_ROW_SERVER_COLWR_EN
    logic col_en;
    assign col_ready_o = serve && !wr_valid_i;
    assign col_en      = col_valid_i && col_ready_o && !flush_i;
`endif

    mat_row_rf #(.SIZE(SIZE), .WIDTH(WIDTH)) u_rf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr_i),
        .rd_row_o    (rd_row_o),
        .peek_addr_i (peek_addr),
        .peek_row_o  (peek_row),
        .wr_en_i     (rf_wr_en),
        .wr_addr_i   (rf_wr_addr),
        .wr_row_i    (rf_wr_row)
`ifdef MAT_ROW_SERVER_COLWR_EN
        ,
        .col_en_i    (col_en),
        .col_addr_i  (col_addr_i),
        .col_i       (col_i)
`endif
    );

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (ld_fire) state_d = ld_last ? SERVE : LOADING;
                LOADING: if (ld_fire && ld_last) state_d = SERVE;
                SERVE:   if (dump_start_fire) state_d = DUMPING;
                DUMPING: if (dump_fire && dump_last) state_d = SERVE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_cnt_q     <= '0;
            rd_valid_o   <= 1'b0;
            rd_addr_o    <= '0;
            dump_valid_o <= 1'b0;
            dump_addr_o  <= '0;
            dump_row_o   <= '0;
        end else begin
            rd_valid_o <= rd_en;
            if (rd_en) begin
                rd_addr_o <= rd_addr_i;
            end
            if (flush_i) begin
                ld_cnt_q     <= '0;
                dump_valid_o <= 1'b0;
                dump_addr_o  <= '0;
            end else begin
                if (ld_fire) begin
                    ld_cnt_q <= ld_last ? '0 : ld_cnt_q + AWL'(1);
                end
                if (dump_start_fire) begin
                    dump_valid_o <= 1'b1;
                    dump_addr_o  <= '0;
                    dump_row_o   <= peek_row;
                end else if (dump_fire) begin
                    if (dump_last) begin
                        dump_valid_o <= 1'b0;
                        dump_addr_o  <= '0;
                    end else begin
                        dump_addr_o <= dump_addr_o + AWL'(1);
                        dump_row_o  <= peek_row;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_row_server.sv
// tb/tb_mat_row_server.sv - directed self-checking bench for mat_row_server
module tb_mat_row_server;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int EW    = 2 * WIDTH;
    localparam int RW    = SIZE * EW;
    localparam int AW    = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic [RW-1:0] ld_row_i;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic          loaded_o;
    logic [AW-1:0] rd_addr_i;
    logic          rd_valid_i;
    logic [RW-1:0] rd_row_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_valid_o;
    logic [RW-1:0] wr_row_i;
    logic [AW-1:0] wr_addr_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic          dump_start_i;
    logic [RW-1:0] dump_row_o;
    logic [AW-1:0] dump_addr_o;
    logic          dump_valid_o;
    logic          dump_ready_i;
    logic          busy_o;
`ifdef MAT_ROW_SERVER_COLWR_EN
    logic [RW-1:0] col_i;
    logic [AW-1:0] col_addr_i;
    logic          col_valid_i;
    logic          col_ready_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mat_row_server #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .ld_row_i     (ld_row_i),
        .ld_valid_i   (ld_valid_i),
        .ld_ready_o   (ld_ready_o),
        .loaded_o     (loaded_o),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_i   (rd_valid_i),
        .rd_row_o     (rd_row_o),
        .rd_addr_o    (rd_addr_o),
        .rd_valid_o   (rd_valid_o),
        .wr_row_i     (wr_row_i),
        .wr_addr_i    (wr_addr_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .dump_start_i (dump_start_i),
        .dump_row_o   (dump_row_o),
        .dump_addr_o  (dump_addr_o),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .busy_o       (busy_o)
`ifdef MAT_ROW_SERVER_COLWR_EN
        ,
        .col_i        (col_i),
        .col_addr_i   (col_addr_i),
        .col_valid_i  (col_valid_i),
        .col_ready_o  (col_ready_o)
`endif
    );

    // kind 0: (i + 0.5j) + j(i - j); kind 1: write-back pattern; kind 2: reload pattern
    function automatic logic [RW-1:0] mk_row(input int i, input int kind);
        logic [RW-1:0] r;
        real re, im;
        r = '0;
        for (int j = 0; j < SIZE; j++) begin
            case (kind)
                0:       begin re = real'(i) + 0.5 * real'(j);  im = real'(i - j); end
                1:       begin re = 100.0 + real'(j);           im = -1.0 * real'(j); end
                default: begin re = 10.0 * real'(i) + real'(j) + 0.25; im = 7.0; end
            endcase
            r[j*EW +: EW] = {$realtobits(im), $realtobits(re)};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load4(input int kind);
        for (int i = 0; i < SIZE; i++) begin
            ld_row_i   = mk_row(i, kind);
            ld_valid_i = 1'b1;
            step();
        end
        ld_valid_i = 1'b0;
    endtask

    task automatic do_read(input int a);
        rd_addr_i  = AW'(a);
        rd_valid_i = 1'b1;
        step();
        rd_valid_i = 1'b0;
    endtask

    logic [RW-1:0] exp_rows [SIZE];

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        ld_row_i = '0; ld_valid_i = 1'b0;
        rd_addr_i = '0; rd_valid_i = 1'b0;
        wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 1'b0;
        dump_start_i = 1'b0; dump_ready_i = 1'b0;
`ifdef MAT_ROW_SERVER_COLWR_EN
        col_i = '0; col_addr_i = '0; col_valid_i = 1'b0;
`endif
        step(); step();
        chk("rst_loaded", RW'(loaded_o), RW'(0));
        chk("rst_ld_ready", RW'(ld_ready_o), RW'(1));
        chk("rst_rd_valid", RW'(rd_valid_o), RW'(0));
        chk("rst_dump_valid", RW'(dump_valid_o), RW'(0));
        chk("rst_rd_row", rd_row_o, '0);
        chk("rst_dump_row", dump_row_o, '0);
        chk("rst_busy", RW'(busy_o), RW'(0));
        rst_i = 1'b0;
        step();

        ld_row_i = mk_row(0, 0); ld_valid_i = 1'b1;
        step();
        chk("load_busy", RW'(busy_o), RW'(1));
        chk("load_not_loaded", RW'(loaded_o), RW'(0));
        for (int i = 1; i < SIZE; i++) begin
            ld_row_i = mk_row(i, 0);
            step();
        end
        ld_valid_i = 1'b0;
        chk("loaded", RW'(loaded_o), RW'(1));
        chk("loaded_ld_ready", RW'(ld_ready_o), RW'(0));
        chk("loaded_wr_ready", RW'(wr_ready_o), RW'(1));

        // load beat in SERVE must be ignored
        ld_row_i = mk_row(0, 1); ld_valid_i = 1'b1;
        step();
        ld_valid_i = 1'b0;

        do_read(2);
        chk("rd2_valid", RW'(rd_valid_o), RW'(1));
        chk("rd2_row", rd_row_o, mk_row(2, 0));
        chk("rd2_addr", RW'(rd_addr_o), RW'(2));
        step();
        chk("rd2_pulse", RW'(rd_valid_o), RW'(0));

        do_read(0);
        chk("rd0_ignored_ld", rd_row_o, mk_row(0, 0));

        rd_addr_i = 2'd3; rd_valid_i = 1'b1;
        step();
        chk("b2b_first", rd_row_o, mk_row(3, 0));
        rd_addr_i = 2'd0;
        step();
        rd_valid_i = 1'b0;
        chk("b2b_second", rd_row_o, mk_row(0, 0));
        chk("b2b_valid", RW'(rd_valid_o), RW'(1));
        chk("b2b_addr", RW'(rd_addr_o), RW'(0));

        rd_addr_i = 2'd1; rd_valid_i = 1'b1;
        wr_addr_i = 2'd1; wr_row_i = mk_row(1, 1); wr_valid_i = 1'b1;
        step();
        rd_valid_i = 1'b0; wr_valid_i = 1'b0;
        chk("rbw_old", rd_row_o, mk_row(1, 0));
        do_read(1);
        chk("rbw_new", rd_row_o, mk_row(1, 1));

        exp_rows[0] = mk_row(0, 0);
        exp_rows[1] = mk_row(1, 1);
        exp_rows[2] = mk_row(2, 0);
        exp_rows[3] = mk_row(3, 0);
        dump_start_i = 1'b1;
        step();
        dump_start_i = 1'b0;
        chk("dump_busy", RW'(busy_o), RW'(1));
        for (int k = 0; k < SIZE; k++) begin
            dump_ready_i = 1'b0;
            step();
            chk($sformatf("dump%0d_valid", k), RW'(dump_valid_o), RW'(1));
            chk($sformatf("dump%0d_addr", k), RW'(dump_addr_o), RW'(k));
            chk($sformatf("dump%0d_row", k), dump_row_o, exp_rows[k]);
            dump_ready_i = 1'b1;
            step();
            dump_ready_i = 1'b0;
        end
        chk("dump_end_valid", RW'(dump_valid_o), RW'(0));
        chk("dump_end_loaded", RW'(loaded_o), RW'(1));

        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_loaded", RW'(loaded_o), RW'(0));
        chk("flush_ld_ready", RW'(ld_ready_o), RW'(1));
        for (int i = 0; i < 2; i++) begin
            ld_row_i = mk_row(i, 2); ld_valid_i = 1'b1;
            step();
        end
        ld_valid_i = 1'b0;
        chk("midload_busy", RW'(busy_o), RW'(1));
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush2_busy", RW'(busy_o), RW'(0));
        do_read(0);
        chk("rd_empty_ignored", RW'(rd_valid_o), RW'(0));
        load4(2);
        chk("reload_loaded", RW'(loaded_o), RW'(1));
        do_read(0);
        chk("reload_row0", rd_row_o, mk_row(0, 2));
        do_read(3);
        chk("reload_row3", rd_row_o, mk_row(3, 2));

        dump_start_i = 1'b1;
        step();
        dump_start_i = 1'b0;
        chk("dump2_valid", RW'(dump_valid_o), RW'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_dump_valid", RW'(dump_valid_o), RW'(0));
        chk("arst_loaded", RW'(loaded_o), RW'(0));
        chk("arst_dump_row", dump_row_o, '0);
        step();
        rst_i = 1'b0;
        step();

`ifdef MAT_ROW_SERVER_COLWR_EN
        load4(0);
        for (int k = 0; k < SIZE; k++) begin
            col_i[k*EW +: EW] = {$realtobits(-3.0), $realtobits(50.0 + real'(k))};
        end
        col_addr_i = 2'd3; col_valid_i = 1'b1;
        #1;
        chk("col_ready", RW'(col_ready_o), RW'(1));
        step();
        col_valid_i = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            exp_rows[k] = mk_row(k, 0);
            exp_rows[k][3*EW +: EW] = col_i[k*EW +: EW];
            do_read(k);
            chk($sformatf("col_row%0d", k), rd_row_o, exp_rows[k]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
